// File: rtl/vram_sched_pkg.sv
// Shared types for the VRAM port scheduler: address/data words and requester ids.
package vram_sched_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {REQ_REGS, REQ_BLIT, REQ_COPP} vram_req_t;

  localparam int VRAM_NREQ = 3;

endpackage

// File: rtl/vram_rr_pick.sv
// Rotating-priority picker: returns the first requester set in req, searching
// upward from start and wrapping modulo three.
module vram_rr_pick
  import vram_sched_pkg::*;
(
  input  logic [VRAM_NREQ-1:0] req,
  input  logic [1:0]           start,
  output logic                 valid,
  output vram_req_t            index
);

  logic [2:0] sum;
  logic [1:0] pos;

  // Walk the search order backwards so the closest position to start wins last.
  always_comb begin
    valid = 1'b0;
    index = REQ_REGS;
    sum   = 3'd0;
    pos   = 2'd0;
    for (int k = VRAM_NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, start} + 3'(k);
      pos = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (req[pos]) begin
        valid = 1'b1;
        index = vram_req_t'(pos);
      end
    end
  end

endmodule

// File: rtl/vram_sched.sv
// VRAM port scheduler: video fetch always wins, leftover cycles are shared
// round-robin between regs, blitter and copper with starvation promotion.
module vram_sched
  import vram_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vgen_sel_i,
  input  addr_t       vgen_addr_i,
  input  logic        regs_sel_i,
  input  logic        regs_wr_i,
  input  logic [3:0]  regs_wr_mask_i,
  input  addr_t       regs_addr_i,
  input  word_t       regs_data_i,
  input  logic        blit_sel_i,
  input  logic        blit_wr_i,
  input  logic [3:0]  blit_wr_mask_i,
  input  addr_t       blit_addr_i,
  input  word_t       blit_data_i,
  input  logic        copp_sel_i,
  input  logic        copp_wr_i,
  input  logic [3:0]  copp_wr_mask_i,
  input  addr_t       copp_addr_i,
  input  word_t       copp_data_i,
  output logic        regs_ack_o,
  output logic        blit_ack_o,
  output logic        copp_ack_o,
  output logic [2:0]  starve_o,
  output logic        vram_wr_o,
  output logic [3:0]  vram_wr_mask_o,
  output addr_t       vram_addr_o,
  output word_t       vram_data_o
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [VRAM_NREQ-1:0] sel;
  logic [VRAM_NREQ-1:0] wr;
  logic [3:0]           mask [VRAM_NREQ];
  addr_t                addr [VRAM_NREQ];
  word_t                data [VRAM_NREQ];

  logic [VRAM_NREQ-1:0] ack_q;
  logic [VRAM_NREQ-1:0] ack_next;
  logic [1:0]           rr_ptr;
  logic [CW-1:0]        wait_cnt [VRAM_NREQ];

  logic [VRAM_NREQ-1:0] eligible;
  logic [VRAM_NREQ-1:0] starved;
  logic                 starved_valid;
  logic                 elig_valid;
  vram_req_t            starved_idx;
  vram_req_t            elig_idx;
  logic                 grant_valid;
  vram_req_t            grant_idx;

  assign sel     = {copp_sel_i, blit_sel_i, regs_sel_i};
  assign wr      = {copp_wr_i, blit_wr_i, regs_wr_i};
  assign mask[0] = regs_wr_mask_i;
  assign mask[1] = blit_wr_mask_i;
  assign mask[2] = copp_wr_mask_i;
  assign addr[0] = regs_addr_i;
  assign addr[1] = blit_addr_i;
  assign addr[2] = copp_addr_i;
  assign data[0] = regs_data_i;
  assign data[1] = blit_data_i;
  assign data[2] = copp_data_i;

  // A requester acked this cycle sits out one cycle before it can win again.
  assign eligible = sel & ~ack_q;

  always_comb begin
    starved  = '0;
    starve_o = '0;
    for (int i = 0; i < VRAM_NREQ; i++) begin
      starve_o[i] = (wait_cnt[i] == LIMIT);
      starved[i]  = eligible[i] && (wait_cnt[i] == LIMIT);
    end
  end

  vram_rr_pick u_pick_starved (
    .req   (starved),
    .start (rr_ptr),
    .valid (starved_valid),
    .index (starved_idx)
  );

  vram_rr_pick u_pick_elig (
    .req   (eligible),
    .start (rr_ptr),
    .valid (elig_valid),
    .index (elig_idx)
  );

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = REQ_REGS;
    if (!vgen_sel_i) begin
      if (starved_valid) begin
        grant_valid = 1'b1;
        grant_idx   = starved_idx;
      end else if (elig_valid) begin
        grant_valid = 1'b1;
        grant_idx   = elig_idx;
      end
    end
  end

  // Unused VRAM lines idle on the regs fields so the mux stays shallow.
  always_comb begin
    vram_wr_o      = 1'b0;
    vram_wr_mask_o = regs_wr_mask_i;
    vram_addr_o    = regs_addr_i;
    vram_data_o    = regs_data_i;
    ack_next       = '0;
    if (vgen_sel_i) begin
      vram_addr_o = vgen_addr_i;
    end else if (grant_valid) begin
      vram_wr_o           = wr[grant_idx];
      vram_wr_mask_o      = mask[grant_idx];
      vram_addr_o         = addr[grant_idx];
      vram_data_o         = data[grant_idx];
      ack_next[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q  <= '0;
      rr_ptr <= 2'd0;
      for (int i = 0; i < VRAM_NREQ; i++) wait_cnt[i] <= '0;
    end else begin
      ack_q <= ack_next;
      if (grant_valid) rr_ptr <= (grant_idx == REQ_COPP) ? 2'd0 : grant_idx + 2'd1;
      for (int i = 0; i < VRAM_NREQ; i++) begin
        if (ack_next[i] || !sel[i]) wait_cnt[i] <= '0;
        else if (eligible[i] && wait_cnt[i] != LIMIT) wait_cnt[i] <= wait_cnt[i] + CW'(1);
      end
    end
  end

  assign regs_ack_o = ack_q[0];
  assign blit_ack_o = ack_q[1];
  assign copp_ack_o = ack_q[2];

endmodule

// File: tb/tb_vram_sched.sv
// Randomized scoreboard bench for vram_sched against a behavioural arbitration model.
module tb_vram_sched;
  import vram_sched_pkg::*;

  localparam int LIMIT = 4;

  typedef struct {
    int idx;
    int due;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       vgen_sel;
  addr_t      vgen_addr;
  logic       t_sel  [3];
  logic       t_wr   [3];
  logic [3:0] t_mask [3];
  addr_t      t_addr [3];
  word_t      t_data [3];

  logic       regs_ack, blit_ack, copp_ack;
  logic [2:0] starve;
  logic       vram_wr;
  logic [3:0] vram_mask;
  addr_t      vram_addr;
  word_t      vram_data;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t sb_q[$];

  int   m_rr;
  int   m_wait [3];
  int   m_last;

  logic [2:0] mon_ack;
  exp_t       mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vram_sched #(.STARVE_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vgen_sel_i     (vgen_sel),
    .vgen_addr_i    (vgen_addr),
    .regs_sel_i     (t_sel[0]),
    .regs_wr_i      (t_wr[0]),
    .regs_wr_mask_i (t_mask[0]),
    .regs_addr_i    (t_addr[0]),
    .regs_data_i    (t_data[0]),
    .blit_sel_i     (t_sel[1]),
    .blit_wr_i      (t_wr[1]),
    .blit_wr_mask_i (t_mask[1]),
    .blit_addr_i    (t_addr[1]),
    .blit_data_i    (t_data[1]),
    .copp_sel_i     (t_sel[2]),
    .copp_wr_i      (t_wr[2]),
    .copp_wr_mask_i (t_mask[2]),
    .copp_addr_i    (t_addr[2]),
    .copp_data_i    (t_data[2]),
    .regs_ack_o     (regs_ack),
    .blit_ack_o     (blit_ack),
    .copp_ack_o     (copp_ack),
    .starve_o       (starve),
    .vram_wr_o      (vram_wr),
    .vram_wr_mask_o (vram_mask),
    .vram_addr_o    (vram_addr),
    .vram_data_o    (vram_data)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int pickFirst(input logic [2:0] set, input int start);
    for (int k = 0; k < 3; k++) begin
      if (set[(start + k) % 3]) return (start + k) % 3;
    end
    return -1;
  endfunction

  task automatic resetModel();
    m_rr   = 0;
    m_last = -1;
    for (int i = 0; i < 3; i++) m_wait[i] = 0;
  endtask

  task automatic setReq(input int i, input logic s, input logic w, input logic [3:0] m,
                        input addr_t a, input word_t d);
    t_sel[i]  = s;
    t_wr[i]   = w;
    t_mask[i] = m;
    t_addr[i] = a;
    t_data[i] = d;
  endtask

  // Drive one cycle of inputs; pending requests are held until acked.
  task automatic applyStimulus(input int mode);
    int pct;
    for (int i = 0; i < 3; i++) begin
      if (t_sel[i] && m_last != i) continue;
      case (mode)
        1:       pct = 100;
        2:       pct = (i == 0) ? 100 : 0;
        3:       pct = 60;
        4:       pct = 0;
        default: pct = 50;
      endcase
      if (int'($urandom_range(0, 99)) < pct)
        setReq(i, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               16'($urandom), 16'($urandom));
      else
        t_sel[i] = 1'b0;
    end
    case (mode)
      0:       vgen_sel = ($urandom_range(0, 3) == 0);
      3:       vgen_sel = ($urandom_range(0, 9) < 8);
      default: vgen_sel = 1'b0;
    endcase
    vgen_addr = 16'($urandom);
  endtask

  // Called at the falling edge: predict this cycle's grant, compare, advance the model.
  task automatic evalCycle();
    logic [2:0] elig, starv, exp_starve;
    int         g;
    logic       e_wr;
    logic [3:0] e_mask;
    addr_t      e_addr;
    word_t      e_data;
    for (int i = 0; i < 3; i++) begin
      elig[i]       = t_sel[i] && (m_last != i);
      starv[i]      = elig[i] && (m_wait[i] == LIMIT);
      exp_starve[i] = (m_wait[i] == LIMIT);
    end
    g = -1;
    if (!vgen_sel) begin
      g = pickFirst(starv, m_rr);
      if (g < 0) g = pickFirst(elig, m_rr);
    end
    e_wr   = 1'b0;
    e_mask = t_mask[0];
    e_addr = t_addr[0];
    e_data = t_data[0];
    if (vgen_sel) e_addr = vgen_addr;
    else if (g >= 0) begin
      e_wr   = t_wr[g];
      e_mask = t_mask[g];
      e_addr = t_addr[g];
      e_data = t_data[g];
    end
    checkOutput("vram_wr", 32'(vram_wr), 32'(e_wr));
    checkOutput("vram_addr", 32'(vram_addr), 32'(e_addr));
    checkOutput("vram_mask", 32'(vram_mask), 32'(e_mask));
    checkOutput("vram_data", 32'(vram_data), 32'(e_data));
    checkOutput("starve", 32'(starve), 32'(exp_starve));
    if (g >= 0) sb_q.push_back('{g, cyc + 1});
    for (int i = 0; i < 3; i++) begin
      if (i == g || !t_sel[i]) m_wait[i] = 0;
      else if (elig[i] && m_wait[i] < LIMIT) m_wait[i]++;
    end
    if (g >= 0) m_rr = (g + 1) % 3;
    m_last = g;
  endtask

  task automatic runCycle(input int mode);
    applyStimulus(mode);
    @(negedge clk);
    evalCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drainIdle();
    for (int n = 0; n < 20; n++) begin
      if (!t_sel[0] && !t_sel[1] && !t_sel[2] && sb_q.size() == 0) break;
      runCycle(4);
    end
  endtask

  // Monitor: every ack the DUT raises must match the oldest outstanding grant.
  initial begin
    forever begin
      @(negedge clk);
      mon_ack = {copp_ack, blit_ack, regs_ack};
      if (mon_ack != 3'b000) begin
        if (sb_q.size() == 0) checkOutput("unexpected_ack", 32'(mon_ack), 32'd0);
        else begin
          mon_e = sb_q.pop_front();
          checkOutput("ack_idx", 32'(mon_ack), 32'(3'b001 << mon_e.idx));
          checkOutput("ack_cycle", 32'(cyc), 32'(mon_e.due));
        end
      end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        mon_e = sb_q.pop_front();
        checkOutput("ack_missing", 32'(mon_ack), 32'(3'b001 << mon_e.idx));
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    vgen_sel  = 1'b0;
    vgen_addr = '0;
    for (int i = 0; i < 3; i++) setReq(i, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    resetModel();
    #1;
    checkOutput("reset_acks", 32'({copp_ack, blit_ack, regs_ack}), 32'd0);
    checkOutput("reset_starve", 32'(starve), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    setReq(0, 1'b1, 1'b1, 4'hF, 16'h1234, 16'hBEEF);
    @(negedge clk);
    checkOutput("first_wr", 32'(vram_wr), 32'd1);
    checkOutput("first_addr", 32'(vram_addr), 32'h1234);
    evalCycle();
    @(posedge clk);
    #1;

    for (int p = 0; p < 6; p++) begin
      for (int n = 0; n < 60; n++) runCycle((p == 4) ? 0 : (p == 5 ? 3 : p));
    end

    drainIdle();
    vgen_sel  = 1'b1;
    vgen_addr = 16'h0ABC;
    setReq(2, 1'b1, 1'b1, 4'h3, 16'h2222, 16'h5555);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      evalCycle();
      @(posedge clk);
      #1;
    end
    checkOutput("copp_starved", 32'(starve[2]), 32'd1);
    vgen_sel = 1'b0;
    setReq(0, 1'b1, 1'b0, 4'h1, 16'h1111, 16'h0000);
    @(negedge clk);
    checkOutput("starved_first", 32'(vram_addr), 32'h2222);
    evalCycle();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_acks", 32'({copp_ack, blit_ack, regs_ack}), 32'd0);
    checkOutput("async_rst_starve", 32'(starve), 32'd0);
    sb_q.delete();
    resetModel();
    for (int i = 0; i < 3; i++) t_sel[i] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_no_ack", 32'({copp_ack, blit_ack, regs_ack}), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int n = 0; n < 40; n++) runCycle(0);
    drainIdle();
    repeat (3) @(posedge clk);
    checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_sched.md
# vram_sched

Three-way scheduler for the single VRAM port, shared by the register interface, blitter and copper. Video generation keeps absolute priority. Leftover cycles go round-robin to the three requesters, with starvation promotion so no requester is locked out under sustained load. It sits between the requesters and the `vram` instance, replacing fixed-priority selection. It drives the VRAM write, mask, address and data lines combinationally and returns registered one-cycle acks.

## Interface
- `STARVE_LIMIT`, default 15: wait cycles after which a pending requester is promoted; must be 1..255.
- `clk` in 1: system clock; all state on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `vgen_sel_i` in 1: video fetch this cycle; always wins, never waits.
- `vgen_addr_i` in addr_t: video read address.
- `regs_sel_i` / `blit_sel_i` / `copp_sel_i` in 1 each: access request; held until the matching ack.
- `*_wr_i` in 1: write (1) or read (0), per requester.
- `*_wr_mask_i` in 4: nibble write mask, per requester.
- `*_addr_i` in addr_t: word address, per requester.
- `*_data_i` in word_t: write data, per requester.
- `regs_ack_o` / `blit_ack_o` / `copp_ack_o` out 1 each: access done; read data valid on `vram_data_i` this cycle.
- `starve_o` out 3: per-requester promoted flag as [copp, blit, regs]; debug/status.
- `vram_wr_o` out 1: VRAM write enable.
- `vram_wr_mask_o` out 4: VRAM write mask.
- `vram_addr_o` out addr_t: VRAM address.
- `vram_data_o` out word_t: VRAM write data.

## Operation
- Requester index order: regs=0, blit=1, copp=2.
- Eligible: `sel & ~ack`. A requester acked this cycle cannot be re-granted this cycle, so at most one grant per two cycles per requester.
- **Grant, combinational, each cycle:**
  1. If `vgen_sel_i`: no requester is granted. VRAM gets `vgen_addr_i` with `wr=0`; mask and data are don't-care and driven from regs.
  2. Else if any eligible requester has `wait_cnt == STARVE_LIMIT`: grant the first such one, searching from `rr_ptr` upward mod 3.
  3. Else: grant the first eligible requester, searching from `rr_ptr` upward mod 3.
  4. With no grant: `vram_wr_o=0` and the other VRAM outputs are driven from regs.
- **Granted requester:** its wr, mask, addr and data go to VRAM; `ack_next[idx]=1`.
- **rr_ptr update:** on a grant, `rr_ptr <= (idx==2) ? 0 : idx+1`. With no grant, it is unchanged. Value 3 is unreachable.
- **wait_cnt per requester**, width `$clog2(STARVE_LIMIT+1)`:
  - granted: cleared;
  - eligible and not granted (including vgen cycles): +1, saturating at STARVE_LIMIT;
  - `sel` low: cleared.
- `starve_o[i] = (wait_cnt[i] == STARVE_LIMIT)`.
- If a requester drops `sel` before its ack, the access already issued still completes and its ack still pulses; its counter clears.

## Timing
- Reset values: all acks 0, `rr_ptr`=0, all `wait_cnt`=0, `starve_o`=0. Reset asserted mid-access drops the pending ack.
- VRAM outputs are combinational from the current inputs and state. There are no registers on the VRAM command path.
- A grant in cycle N gives ack high in N+1 for exactly one cycle. For reads, `vram_data_i` is valid in N+1.
- Worst case with vgen idle: a requester is granted within 3 cycles of becoming eligible.
- With vgen busy, promotion keeps the bound at STARVE_LIMIT + 3 cycles after vgen releases.
- Simultaneous starved requesters are served in rr order, one per cycle.

## Structure
- Add to `xosera_pkg`: `typedef enum logic [1:0] {REQ_REGS, REQ_BLIT, REQ_COPP} vram_req_t;` and `VRAM_NREQ = 3`. `addr_t` and `word_t` are already there.
- Sub-module `vram_rr_pick`: combinational 3-input rotating-priority picker.
  - Inputs: 3-bit request, 2-bit start.
  - Outputs: valid and index.
  - Instanced twice: starved set and eligible set.
- `vram` stays a separate instance at the parent, wired to `vram_*_o` and `vram_data_i`.

## Test plan
- **Reset then single request:** deassert `reset_n`, hold `regs_sel_i=1`, `regs_wr_i=1`, addr 0x1234, data 0xBEEF, mask 0xF. Expect `vram_wr_o=1` and addr 0x1234 in that cycle, `regs_ack_o` for one cycle next cycle, then readback 0xBEEF.
- **vgen preemption:** `vgen_sel_i=1` for 5 cycles with blit pending. Expect VRAM addr = `vgen_addr_i` and `vram_wr_o=0` throughout; `blit_ack_o` follows one cycle after vgen drops.
- **Round-robin fairness:** all three `sel` held high for 12 cycles. Expect grant order regs, blit, copp repeating, with each ack rising every third cycle after the first.
- **Starvation:** `STARVE_LIMIT=4`, vgen high for 6 cycles with copp pending and `rr_ptr`=0. Expect `starve_o[2]=1` after 4 cycles, and copp granted first when vgen drops, ahead of a concurrently pending regs.
- **Back-to-back guard:** `regs_sel_i` held high alone for 6 cycles. Expect grants in cycles 0, 2 and 4, and acks in cycles 1, 3 and 5.
- **Async reset mid-access:** grant in cycle N, `reset_n` low before edge N+1. Expect no ack and all outputs at reset values immediately.
